// File: rtl/chino_dmem_arbiter.sv
// rtl/chino_dmem_arbiter.sv - two-master round-robin arbiter in front of the data RAM
module chino_dmem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  // master 0: CPU load/store
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_stall_o,
  // master 1: DMA/debug
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  // data RAM
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;       // master owning the access in flight
  logic        last_q, last_d;     // master granted most recently
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic req0_elig, req1_elig, pick, in_access;

  // The master being acknowledged may not win the very next grant.
  assign req0_elig = m0_req && !(state_q == RESP && !gnt_q);
  assign req1_elig = m1_req && !(state_q == RESP && gnt_q);
  assign pick      = (req0_elig && req1_elig) ? ~last_q : req1_elig;
  assign in_access = (state_q == ACCESS);

  // Next-state: arbitration, request latching, wait counting, read capture.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!we_q) begin
            if (gnt_q) rdata1_d = ram_data_i;
            else       rdata0_d = ram_data_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (req0_elig || req1_elig) begin
          state_d = ACCESS;
          gnt_d   = pick;
          last_d  = pick;
          cnt_d   = CNT_LOAD;
          we_d    = pick ? m1_we    : m0_we;
          addr_d  = pick ? m1_addr  : m0_addr;
          sel_d   = pick ? m1_sel   : m0_sel;
          wdata_d = pick ? m1_wdata : m0_wdata;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register; reset aborts any access and favours master 0 on the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ram_ce_o   = in_access;
  assign ram_we_o   = in_access & we_q;
  assign ram_addr_o = in_access ? addr_q  : '0;
  assign ram_sel_o  = in_access ? sel_q   : '0;
  assign ram_data_o = in_access ? wdata_q : '0;

  assign m0_ack     = (state_q == RESP) && !gnt_q;
  assign m1_ack     = (state_q == RESP) && gnt_q;
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;
  assign m0_stall_o = m0_req & ~m0_ack;

endmodule
